// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: store sizes, result codes,
// monitor states and the expected-store record.
package store_monitor_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      WORD = 2'b01,
      HALF = 2'b10,
      BYTE = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISMATCH = 2'b01,
      FC_TIMEOUT  = 2'b10,
      FC_EMPTY    = 2'b11
   } fail_code_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      PASS = 2'b10,
      FAIL = 2'b11
   } mon_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      mem_size_e   size;
   } exp_entry_t;

   function automatic logic [31:0] size_mask(input mem_size_e sz);
      logic [31:0] m;
      case (sz)
         WORD:    m = 32'hFFFF_FFFF;
         HALF:    m = 32'h0000_FFFF;
         BYTE:    m = 32'h0000_00FF;
         default: m = 32'h0000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/store_monitor_exp_fifo.sv
// In-order list of expected stores; head entry is always presented
// combinationally so the monitor can compare without an extra cycle.
module exp_fifo
   import store_monitor_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_push,
   input  exp_entry_t    i_entry,
   input  logic          i_pop,
   output exp_entry_t    o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [IW-1:0] o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   exp_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [IW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == IW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= nxt(r_wptr);
         if (w_pop)  r_rptr <= nxt(r_rptr);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_entry;
   end

endmodule

// File: rtl/store_monitor.sv
// Checks data-memory stores against a programmed in-order list and
// latches pass / mismatch / timeout / empty-list results.
module store_monitor
   import store_monitor_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int STRICT  = 1,
   parameter int IW      = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          exp_valid,
   output logic          exp_ready,
   input  logic [31:0]   exp_addr,
   input  logic [31:0]   exp_data,
   input  logic [1:0]    exp_size,
   input  logic          start,
   input  logic          clear,
   input  logic [1:0]    memwrite,
   input  logic [31:0]   dataadr,
   input  logic [31:0]   writedata,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [1:0]    fail_code,
   output logic [IW-1:0] fail_index,
   output logic [IW-1:0] matched
);

   mon_state_e    r_state;
   fail_code_e    r_fcode;
   logic [IW-1:0] r_fidx;
   logic [IW-1:0] r_matched;
   logic [31:0]   r_timer;

   exp_entry_t    w_entry;
   exp_entry_t    w_head;
   logic          w_full;
   logic          w_empty;
   logic [IW-1:0] w_count;
   logic          w_push;
   logic          w_pop;
   logic          w_run;
   logic          w_store;
   logic          w_addr_eq;
   logic          w_hit;
   logic          w_bad;
   logic          w_tmo;
   logic [31:0]   w_mask;

   assign w_entry = '{addr: exp_addr, data: exp_data,
                      size: mem_size_e'(exp_size)};

   exp_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_clear (clear),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign exp_ready = (r_state == IDLE) && !w_full && !clear;
   assign w_push    = exp_valid && exp_ready;

   // Upper bytes of half/byte stores are don't-care on both sides.
   assign w_run     = (r_state == RUN);
   assign w_store   = (memwrite != 2'b00);
   assign w_addr_eq = (dataadr == w_head.addr);
   assign w_mask    = size_mask(w_head.size);
   assign w_hit     = w_addr_eq
                   && (mem_size_e'(memwrite) == w_head.size)
                   && (((writedata ^ w_head.data) & w_mask) == '0);
   assign w_bad     = w_store && !w_hit && (w_addr_eq || STRICT != 0);
   assign w_pop     = w_run && w_store && w_hit && !clear;
   assign w_tmo     = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_fcode   <= FC_NONE;
         r_fidx    <= '0;
         r_matched <= '0;
         r_timer   <= '0;
      end else if (clear) begin
         r_state   <= IDLE;
         r_fcode   <= FC_NONE;
         r_fidx    <= '0;
         r_matched <= '0;
         r_timer   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_timer <= '0;
                  if (w_empty) begin
                     r_state <= FAIL;
                     r_fcode <= FC_EMPTY;
                     r_fidx  <= '0;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               // A match beats a timeout landing on the same edge.
               if (w_pop) begin
                  r_matched <= r_matched + 1'b1;
                  r_timer   <= '0;
                  if (w_count == IW'(1)) r_state <= PASS;
               end else if (w_bad) begin
                  r_state <= FAIL;
                  r_fcode <= FC_MISMATCH;
                  r_fidx  <= r_matched;
               end else if (w_tmo) begin
                  r_state <= FAIL;
                  r_fcode <= FC_TIMEOUT;
                  r_fidx  <= r_matched;
               end else if (TIMEOUT != 0) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            PASS, FAIL: ;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = (r_state == RUN);
   assign done       = (r_state == PASS) || (r_state == FAIL);
   assign pass       = (r_state == PASS);
   assign fail_code  = r_fcode;
   assign fail_index = r_fidx;
   assign matched    = r_matched;

endmodule
